// File: rtl/serial_adder.sv
// Multi-cycle adder/subtractor: BITS_PER_CYCLE bits per clock, LSB first, registered carry.
// Results land on sum/cout/ovf only at the completing edge and hold until the next completion.

module sa_fa_cell (
  input  logic a,
  input  logic b,
  input  logic ci,
  output logic s,
  output logic co
);
  assign s  = a ^ b ^ ci;
  assign co = (a & b) | (ci & (a ^ b));
endmodule

module serial_adder #(
  parameter int WIDTH          = 8,
  parameter int BITS_PER_CYCLE = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             sub,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             ready,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf
);
  localparam int BPC = BITS_PER_CYCLE;
  localparam int N   = WIDTH / BPC;
  localparam int CW  = $clog2(N + 1);
  localparam logic [CW-1:0] LAST_CNT = CW'(N - 1);

  if (WIDTH < 2) begin : g_bad_width
    $error("serial_adder: WIDTH must be at least 2");
  end
  if (BPC < 1 || (WIDTH % BPC) != 0) begin : g_bad_bpc
    $error("serial_adder: BITS_PER_CYCLE must divide WIDTH evenly");
  end

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

  typedef struct packed {
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             ci;
  } op_t;

  state_t           state, state_nxt;
  op_t              op_ld;
  logic             accept, last;
  logic [WIDTH-1:0] a_sh, b_sh, res_nxt;
  logic             carry;
  logic [CW-1:0]    cnt;
  logic [BPC-1:0]   ch_s;
  logic [BPC:0]     ch_c;

  // Subtract is a + ~b + 1, so the inversion and the forced carry happen at load time.
  assign op_ld  = '{a: a, b: (sub ? ~b : b), ci: (sub | cin)};
  assign accept = start & ready;
  assign last   = (state == S_RUN) && (cnt == LAST_CNT);

  // ---------------- FSM ----------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= S_IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:  state_nxt = accept ? S_RUN : S_IDLE;
      S_RUN:   state_nxt = last   ? S_DONE : S_RUN;
      S_DONE:  state_nxt = accept ? S_RUN : S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    ready = 1'b0;
    busy  = 1'b0;
    done  = 1'b0;
    case (state)
      S_IDLE: ready = 1'b1;
      S_RUN:  busy  = 1'b1;
      S_DONE: begin
        ready = 1'b1;
        done  = 1'b1;
      end
      default: ready = 1'b0;
    endcase
  end

  // ---------------- chunk adder ----------------
  assign ch_c[0] = carry;
  for (genvar i = 0; i < BPC; i++) begin : g_lane
    sa_fa_cell u_fa (
      .a  (a_sh[i]),
      .b  (b_sh[i]),
      .ci (ch_c[i]),
      .s  (ch_s[i]),
      .co (ch_c[i+1])
    );
  end

  // The result register only needs the chunks already produced; the last chunk goes straight to sum.
  if (N == 1) begin : g_res_single
    assign res_nxt = ch_s;
  end else begin : g_res_shift
    logic [WIDTH-BPC-1:0] res_sh;
    assign res_nxt = {ch_s, res_sh};
    always_ff @(posedge clk or posedge rst) begin
      if (rst)                 res_sh <= '0;
      else if (state == S_RUN) res_sh <= res_nxt[WIDTH-1:BPC];
    end
  end

  // ---------------- datapath ----------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      a_sh  <= '0;
      b_sh  <= '0;
      carry <= 1'b0;
      cnt   <= '0;
      sum   <= '0;
      cout  <= 1'b0;
      ovf   <= 1'b0;
    end else if (accept) begin
      a_sh  <= op_ld.a;
      b_sh  <= op_ld.b;
      carry <= op_ld.ci;
      cnt   <= '0;
    end else if (state == S_RUN) begin
      a_sh  <= a_sh >> BPC;
      b_sh  <= b_sh >> BPC;
      carry <= ch_c[BPC];
      cnt   <= cnt + CW'(1);
      if (last) begin
        sum  <= res_nxt;
        cout <= ch_c[BPC];
        ovf  <= ch_c[BPC] ^ ch_c[BPC-1];
      end
    end
  end
endmodule

// File: doc/serial_adder.md
Name: serial_adder

Overview:
Parametrised multi-cycle adder/subtractor. Processes two WIDTH-bit operands BITS_PER_CYCLE bits per clock, LSB first, through a registered carry. It replaces one-shot combinational half/full adders where area matters more than latency. It sits behind a start/ready/done handshake so a control FSM can issue back-to-back operations.

Parameters:
WIDTH, 8, operand and result width in bits; must be at least 2.
BITS_PER_CYCLE, 1, bits processed per clock. Must divide WIDTH evenly; elaboration fails otherwise.

Ports:
clk  input  1  clock; all state changes on the rising edge.
rst  input  1  asynchronous, active-high reset.
start  input  1  request an operation; sampled only while ready=1.
sub  input  1  0 selects a+b+cin; 1 selects a-b (cin is ignored).
a  input  WIDTH  operand A; sampled on the accepting edge.
b  input  WIDTH  operand B; sampled on the accepting edge.
cin  input  1  carry-in for add; sampled on the accepting edge.
ready  output  1  high when a start will be accepted.
busy  output  1  high while chunks are being processed.
done  output  1  one-cycle pulse; results are valid from this cycle.
sum  output  WIDTH  result.
cout  output  1  carry-out. For subtract, 1 means no borrow.
ovf  output  1  signed overflow.

Behaviour:
- N = WIDTH/BITS_PER_CYCLE. Chunk counter width is clog2(N+1).
- States: IDLE, RUN, DONE.
  - IDLE: ready=1, busy=0, done=0.
  - RUN: ready=0, busy=1.
  - DONE: ready=1, busy=0, done=1.
- Accept: start=1 while ready=1 (IDLE or DONE).
  - On the accepting edge: latch a into shift register A.
  - Latch b, or ~b when sub=1, into shift register B.
  - Carry register gets cin when sub=0, or 1 when sub=1.
  - Clear the chunk counter; enter RUN.
- RUN, each edge:
  - Add the low BITS_PER_CYCLE bits of A, B and the carry through a full-adder chain.
  - Shift the chunk result into the result register from the MSB side; shift A and B right by BITS_PER_CYCLE.
  - Update the carry; increment the counter.
  - On the Nth RUN edge, enter DONE.
- Latency: with accept at edge 0, results are registered at edge N. done is high for exactly the cycle after edge N.
- Results:
  - sum is the full WIDTH result. cout is the final carry.
  - ovf = (carry into the MSB) XOR (carry out of the MSB), captured during the last chunk.
- Output holding:
  - sum, cout and ovf change only at edge N of an operation.
  - They hold until the next operation completes; intermediate shifting is not visible on sum.
  - The internal result register is separate from the sum output register.
- DONE leaves after one cycle:
  - with start=1: accept and enter RUN (back-to-back, no idle gap);
  - otherwise: enter IDLE.
- start while busy=1 is ignored, with no effect on state or results. a, b, cin and sub may change freely after the accepting edge.
- Reset, asynchronous and applicable at any time including mid-RUN:
  - state IDLE, ready=1, busy=0, done=0;
  - sum=0, cout=0, ovf=0;
  - counter, carry and shift registers cleared;
  - an interrupted operation produces no done.
- No X propagation: all registers have defined reset values.

Test Plan:
1. WIDTH=8, BPC=1: a=8'h3C, b=8'h42, cin=0, sub=0 -> done exactly 8 cycles after accept; sum=8'h7E, cout=0, ovf=0. busy is high for 8 cycles and ready is low during them.
2. a=8'hFF, b=8'h01, cin=1, add -> sum=8'h01, cout=1, ovf=0. Then a=8'h7F, b=8'h01, cin=0 -> sum=8'h80, cout=0, ovf=1.
3. sub=1, a=8'h10, b=8'h20, cin=1 (ignored) -> sum=8'hF0, cout=0, ovf=0. Then sub=1, a=8'h80, b=8'h01 -> sum=8'h7F, cout=1, ovf=1.
4. start pulsed at RUN cycle 3 with different operands -> ignored; result is still that of the original operands. Operands changed after accept do not affect the result.
5. rst asserted mid-RUN (cycle 4) between clock edges -> ready=1 and sum=0 immediately; no done pulse. A fresh start then completes correctly in 8 cycles.
6. Back-to-back and chunked:
   - BPC=1: start held high in the DONE cycle -> second operation accepted with no idle cycle; first result stays on sum until the second done.
   - WIDTH=8, BPC=4: latency 2 cycles, results identical to scenarios 1-3.
   - WIDTH=16, BPC=2: 16'hFFFF+16'h0001 -> sum=16'h0000, cout=1.
